operand_feeder: RTL and testbench

OPERAND_FEEDER -- requirements
Module: operand_feeder

---
 rtl/operand_feeder.sv | 103 ++++++++++
 tb/tb_operand_feeder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_feeder.sv
// operand_feeder: FIFO-fed single-job compute issuer with result hold; FEEDER_TIMEOUT_EN adds a WAIT watchdog
module operand_feeder #(
  parameter int          DEPTH   = 4,
  parameter logic [23:0] TIMEOUT = 24'd1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        in_ready,
  output logic        cu_start,
  output logic [15:0] cu_a,
  output logic [15:0] cu_b,
  input  logic        cu_ready,
  input  logic [15:0] cu_y,
  output logic        res_valid,
  output logic [15:0] res_y,
  input  logic        res_ready,
  output logic [15:0] jobs_done,
  output logic        busy
`ifdef FEEDER_TIMEOUT_EN
  ,
  output logic        err_timeout
`endif
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t state;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic push, pop;
`ifdef FEEDER_TIMEOUT_EN
  logic [23:0] timer;
`else
  logic [23:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
`endif
  assign in_ready = count != (AW+1)'(DEPTH);
  assign push = in_valid && in_ready;
  assign pop = state == IDLE && count != '0;
  assign busy = state != IDLE || count != '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {in_a, in_b};
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cu_start <= 1'b0;
      cu_a <= '0;
      cu_b <= '0;
      res_valid <= 1'b0;
      res_y <= '0;
      jobs_done <= '0;
`ifdef FEEDER_TIMEOUT_EN
      timer <= '0;
      err_timeout <= 1'b0;
`endif
    end else
      case (state)
        IDLE:
          if (pop) begin
            {cu_a, cu_b} <= mem[rd_ptr];
            cu_start <= 1'b1;
            state <= ISSUE;
          end
        ISSUE: begin
          cu_start <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
          timer <= '0;
`endif
          state <= WAIT;
        end
        WAIT:
          if (cu_ready) begin
            res_y <= cu_y;
            res_valid <= 1'b1;
            state <= HOLD;
          end
`ifdef FEEDER_TIMEOUT_EN
          else if (timer == TIMEOUT - 24'd1) begin
            err_timeout <= 1'b1;
            state <= IDLE;
          end else timer <= timer + 24'd1;
`endif
        HOLD:
          if (res_ready) begin
            res_valid <= 1'b0;
            jobs_done <= jobs_done + 1'b1;
            state <= IDLE;
          end
      endcase
endmodule

// File: tb/tb_operand_feeder.sv
// tb_operand_feeder: directed bench with a behavioural compute responder and an event-level reference model
module tb_operand_feeder;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, cu_start, cu_ready, res_valid, res_ready, busy;
  logic [15:0] in_a, in_b, cu_a, cu_b, cu_y, res_y, jobs_done;
`ifdef FEEDER_TIMEOUT_EN
  logic err_timeout;
`endif
  int errors = 0, checks = 0, cyc = 0;
  int starts = 0, start_cyc = 0, push_cyc = 0, rv_cnt = 0, model_jobs = 0, dly = 5, left = 0;
  bit stall = 0, pending = 0;
  logic [15:0] got [$];
  logic [31:0] pushq [$];
  logic [31:0] cur, pend_pair;
  bit inflight = 0, push_pend = 0, exp_start = 0, prev_rv = 0, prev_rr = 0, prev_err = 0;
  logic [15:0] prev_y;

  operand_feeder #(.DEPTH(DEPTH), .TIMEOUT(24'd100)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b), .in_ready(in_ready),
    .cu_start(cu_start), .cu_a(cu_a), .cu_b(cu_b), .cu_ready(cu_ready), .cu_y(cu_y),
    .res_valid(res_valid), .res_y(res_y), .res_ready(res_ready), .jobs_done(jobs_done), .busy(busy)
`ifdef FEEDER_TIMEOUT_EN
    , .err_timeout(err_timeout)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] f(input logic [15:0] a, input logic [15:0] b);
    longint r;
    r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= longint'(b)) r++;
    return 16'(longint'(a) * longint'(a) + r);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  initial begin
    cu_ready = 1'b0;
    cu_y = '0;
    forever begin
      @(posedge clk);
      #1;
      cu_ready = 1'b0;
      if (cu_start) begin
        pending = 1;
        left = dly;
      end else if (pending && !stall) begin
        if (left <= 1) begin
          cu_ready = 1'b1;
          cu_y = f(cu_a, cu_b);
          pending = 0;
        end else left--;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      pushq.delete();
      inflight = 0;
      push_pend = 0;
      exp_start = 0;
      prev_rv = 0;
      prev_rr = 0;
      prev_err = 0;
      model_jobs = 0;
    end else begin
      if (push_pend) pushq.push_back(pend_pair);
`ifdef FEEDER_TIMEOUT_EN
      if (err_timeout && !prev_err) inflight = 0;
      prev_err = err_timeout;
`endif
      chk("cu_start", 32'(cu_start), 32'(exp_start));
      if (cu_start) begin
        if (pushq.size() != 0) cur = pushq.pop_front();
        inflight = 1;
        starts++;
        start_cyc = cyc;
      end
      if (inflight) chk("cu_operands", {cu_a, cu_b}, cur);
      chk("in_ready", 32'(in_ready), 32'(pushq.size() != DEPTH));
      chk("busy", 32'(busy), 32'(inflight || pushq.size() != 0));
      chk("jobs_done", 32'(jobs_done), 32'(16'(model_jobs)));
      if (prev_rv && !prev_rr) begin
        chk("res_valid_hold", 32'(res_valid), 32'd1);
        chk("res_y_hold", 32'(res_y), 32'(prev_y));
      end
      if (!inflight) chk("res_valid_idle", 32'(res_valid), 32'd0);
      exp_start = !inflight && pushq.size() != 0;
      if (res_valid) rv_cnt++;
      if (res_valid && res_ready) begin
        chk("res_y", 32'(res_y), 32'(f(cur[31:16], cur[15:0])));
        got.push_back(res_y);
        model_jobs++;
        inflight = 0;
      end
      push_pend = in_valid && in_ready;
      pend_pair = {in_a, in_b};
      prev_rv = res_valid;
      prev_rr = res_ready;
      prev_y = res_y;
    end
  end

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    int n;
    @(posedge clk);
    #1;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL push_accept: in_ready stayed 0 for pair %0d,%0d", a, b);
    end
    @(posedge clk);
    #1;
    push_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_jobs(input int n);
    int k;
    k = 0;
    @(negedge clk);
    while (jobs_done != 16'(n) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (jobs_done != 16'(n)) begin
      checks++;
      errors++;
      $display("FAIL wait_jobs: jobs_done=%0d required %0d", jobs_done, n);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, s0, r0, k;
    logic [15:0] y0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_y", 32'(res_y), 32'd0);
    chk("rst_cu_ab", {cu_a, cu_b}, 32'd0);
    chk("rst_jobs", 32'(jobs_done), 32'd0);
`ifdef FEEDER_TIMEOUT_EN
    chk("rst_err", 32'(err_timeout), 32'd0);
`endif
    base = got.size();
    s0 = starts;
    r0 = rv_cnt;
    push(16'd3, 16'd27);
    wait_jobs(1);
    chk("single_res", 32'(got[base]), 32'd12);
    chk("single_starts", 32'(starts - s0), 32'd1);
    chk("single_rv_cycles", 32'(rv_cnt - r0), 32'd1);
    chk("single_latency", 32'(start_cyc - push_cyc), 32'd1);
    @(posedge clk);
    #1;
    stall = 1;
    base = got.size();
    push(16'd7, 16'd0);
    repeat (3) @(negedge clk);
    push(16'd1, 16'd1);
    push(16'd2, 16'd8);
    push(16'd4, 16'd64);
    push(16'd0, 16'd0);
    @(negedge clk);
    chk("fill_full", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    stall = 0;
    push(16'd10, 16'd1000);
    wait_jobs(7);
    chk("fill_r0", 32'(got[base]), 32'd49);
    chk("fill_r1", 32'(got[base+1]), 32'd2);
    chk("fill_r2", 32'(got[base+2]), 32'd6);
    chk("fill_r3", 32'(got[base+3]), 32'd20);
    chk("fill_r4", 32'(got[base+4]), 32'd0);
    chk("fill_r5", 32'(got[base+5]), 32'd110);
    @(posedge clk);
    #1;
    dly = 2;
    res_ready = 1'b0;
    base = got.size();
    push(16'd9, 16'd27);
    k = 0;
    while (!res_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    y0 = res_y;
    chk("bp_first", 32'(y0), 32'd84);
    push(16'd1, 16'd0);
    push(16'd2, 16'd0);
    push(16'd3, 16'd0);
    push(16'd4, 16'd0);
    s0 = starts;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_res_y", 32'(res_y), 32'd84);
      chk("bp_res_valid", 32'(res_valid), 32'd1);
    end
    chk("bp_full", 32'(in_ready), 32'd0);
    chk("bp_no_start", 32'(starts - s0), 32'd0);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    wait_jobs(12);
    chk("bp_r1", 32'(got[base+1]), 32'd1);
    chk("bp_r2", 32'(got[base+2]), 32'd4);
    chk("bp_r3", 32'(got[base+3]), 32'd9);
    chk("bp_r4", 32'(got[base+4]), 32'd16);
    @(posedge clk);
    #1;
    stall = 1;
    dly = 3;
    push(16'd2, 16'd0);
    push(16'd3, 16'd0);
    push(16'd4, 16'd0);
    push(16'd5, 16'd0);
    repeat (2) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    stall = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_res_valid", 32'(res_valid), 32'd0);
    chk("mid_jobs", 32'(jobs_done), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    chk("mid_busy_clr", 32'(busy), 32'd0);
    repeat (8) begin
      @(negedge clk);
      chk("mid_stale", 32'(res_valid), 32'd0);
    end
    push(16'd4, 16'd8);
    wait_jobs(1);
    chk("mid_after", 32'(got[got.size()-1]), 32'd18);
`ifdef FEEDER_TIMEOUT_EN
    do_reset();
    stall = 1;
    dly = 4;
    push(16'd5, 16'd0);
    push(16'd6, 16'd8);
    k = 0;
    @(negedge clk);
    while (!err_timeout && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk("to_flag", 32'(err_timeout), 32'd1);
    chk("to_cycles", 32'(cyc - start_cyc), 32'd101);
    @(posedge clk);
    #1;
    stall = 0;
    wait_jobs(1);
    chk("to_next_res", 32'(got[got.size()-1]), 32'd38);
    chk("to_sticky", 32'(err_timeout), 32'd1);
    do_reset();
    @(negedge clk);
    chk("to_rst_err", 32'(err_timeout), 32'd0);
`endif
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
